// File: rtl/gtfmac_vnc_lat_stats_mc_if.sv
// Bus bundle for the multi-channel latency statistics engine.
// master: control/event source and readout consumer (drives go, clear, targets, events, selects).
// slave : the statistics engine (drives busy/done and the registered rd_* readout).
// Signals:
//   go, clear, lat_pkt_cnt[31:0], send_event[NCH], rcv_event[NCH], rd_ch, rd_bin  (master -> slave)
//   busy, done, rd_cnt[31:0], rd_accu, rd_min, rd_max, rd_ovf, rd_unf, rd_hist[31:0] (slave -> master)
interface gtfmac_vnc_lat_stats_mc_if #(
   parameter int unsigned NCH         = 4,
   parameter int unsigned TIMER_WIDTH = 16,
   parameter int unsigned ACCU_WIDTH  = 32,
   parameter int unsigned HIST_BINS   = 16
);
   localparam int unsigned CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int unsigned BIN_W = (HIST_BINS > 1) ? $clog2(HIST_BINS) : 1;

   logic                   go;
   logic                   clear;
   logic [31:0]            lat_pkt_cnt;
   logic [NCH-1:0]         send_event;
   logic [NCH-1:0]         rcv_event;
   logic [CH_W-1:0]        rd_ch;
   logic [BIN_W-1:0]       rd_bin;
   logic                   busy;
   logic                   done;
   logic [31:0]            rd_cnt;
   logic [ACCU_WIDTH-1:0]  rd_accu;
   logic [TIMER_WIDTH-1:0] rd_min;
   logic [TIMER_WIDTH-1:0] rd_max;
   logic                   rd_ovf;
   logic                   rd_unf;
   logic [31:0]            rd_hist;

   modport master (
      output go, clear, lat_pkt_cnt, send_event, rcv_event, rd_ch, rd_bin,
      input  busy, done, rd_cnt, rd_accu, rd_min, rd_max, rd_ovf, rd_unf, rd_hist
   );

   modport slave (
      input  go, clear, lat_pkt_cnt, send_event, rcv_event, rd_ch, rd_bin,
      output busy, done, rd_cnt, rd_accu, rd_min, rd_max, rd_ovf, rd_unf, rd_hist
   );
endinterface

// File: rtl/gtfmac_vnc_lat_stats_mc.sv
// Multi-channel latency statistics engine (lat_clk domain).
// One free-running timer timestamps per-channel send events into an in-order FIFO; each
// receive pops the oldest outstanding send and yields delta = timer - stamp (mod 2^TIMER_WIDTH).
// Per channel: sample count, saturating delta sum, min, max, sticky overflow/underflow.
// Ports:
//   lat_clk   clock for all logic
//   lat_rstn  asynchronous active-low reset
//   bus       slave side of gtfmac_vnc_lat_stats_mc_if (control, events, registered readout)
// Optional feature: define GTFMAC_VNC_LAT_HIST_EN to add a per-channel delta histogram
// (bin = min(delta >> HIST_SHIFT, HIST_BINS-1), 32-bit saturating counters, read via rd_bin).
// Without it rd_hist is tied to zero and rd_bin is ignored.
module gtfmac_vnc_lat_stats_mc #(
   parameter int unsigned NCH         = 4,
   parameter int unsigned TIMER_WIDTH = 16,
   parameter int unsigned OUTST_DEPTH = 8,
   parameter int unsigned ACCU_WIDTH  = 32,
   parameter int unsigned HIST_BINS   = 16,
   parameter int unsigned HIST_SHIFT  = 2
) (
   input logic                      lat_clk,
   input logic                      lat_rstn,
   gtfmac_vnc_lat_stats_mc_if.slave bus
);
   localparam int unsigned CH_W   = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int unsigned IDX_W  = (OUTST_DEPTH > 1) ? $clog2(OUTST_DEPTH) : 1;
   localparam int unsigned FILL_W = $clog2(OUTST_DEPTH + 1);
   localparam int unsigned SUM_W  = ACCU_WIDTH + 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e                 state_q;
   logic                   busy_q, done_q, go_q;
   logic [TIMER_WIDTH-1:0] timer_q;

   logic [TIMER_WIDTH-1:0] fifo_mem_q [NCH][OUTST_DEPTH];
   logic [IDX_W-1:0]       wr_idx_q   [NCH];
   logic [IDX_W-1:0]       rd_idx_q   [NCH];
   logic [FILL_W-1:0]      fill_q     [NCH];
   logic [NCH-1:0]         ovf_q, unf_q;

   logic [NCH-1:0]         dly_vld_q;
   logic [TIMER_WIDTH-1:0] dly_q      [NCH];
   logic [31:0]            cnt_q      [NCH];
   logic [ACCU_WIDTH-1:0]  accu_q     [NCH];
   logic [TIMER_WIDTH-1:0] min_q      [NCH];
   logic [TIMER_WIDTH-1:0] max_q      [NCH];

   logic [31:0]            rd_cnt_q;
   logic [ACCU_WIDTH-1:0]  rd_accu_q;
   logic [TIMER_WIDTH-1:0] rd_min_q, rd_max_q;
   logic                   rd_ovf_q, rd_unf_q;

   logic                   run, clr, go_rise, go_fall, all_hit;
   logic [NCH-1:0]         empty, full, push, pop, set_ovf, set_unf, take;
   logic [SUM_W-1:0]       accu_sum   [NCH];

   always_comb begin
      run     = (state_q == StRun);
      clr     = bus.clear && (state_q != StRun);
      go_rise = bus.go && !go_q;
      go_fall = !bus.go && go_q;
      all_hit = (bus.lat_pkt_cnt != '0);
      empty   = '0;
      full    = '0;
      push    = '0;
      pop     = '0;
      set_ovf = '0;
      set_unf = '0;
      take    = '0;
      for (int unsigned c = 0; c < NCH; c++) begin
         empty[c]    = (fill_q[c] == '0);
         full[c]     = (fill_q[c] == FILL_W'(OUTST_DEPTH));
         pop[c]      = run && bus.rcv_event[c] && !empty[c];
         // A same-cycle receive frees the head slot, so a full FIFO still accepts the push.
         push[c]     = run && bus.send_event[c] && (!full[c] || bus.rcv_event[c]);
         set_ovf[c]  = run && bus.send_event[c] && full[c] && !bus.rcv_event[c];
         set_unf[c]  = run && bus.rcv_event[c] && empty[c];
         take[c]     = dly_vld_q[c] &&
                       ((bus.lat_pkt_cnt == '0) || (cnt_q[c] < bus.lat_pkt_cnt));
         accu_sum[c] = {1'b0, accu_q[c]} + SUM_W'(dly_q[c]);
         if (cnt_q[c] < bus.lat_pkt_cnt) all_hit = 1'b0;
      end
   end

   // Timer and control FSM; busy/done are registered alongside the state.
   always_ff @(posedge lat_clk or negedge lat_rstn) begin
      if (!lat_rstn) begin
         timer_q <= '0;
         go_q    <= 1'b0;
         state_q <= StIdle;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         timer_q <= timer_q + TIMER_WIDTH'(1);
         go_q    <= bus.go;
         unique case (state_q)
            StIdle: begin
               if (go_rise) begin
                  state_q <= StRun;
                  busy_q  <= 1'b1;
               end
            end
            StRun: begin
               if (go_fall || all_hit) begin
                  state_q <= StDone;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            StDone: begin
               if (bus.clear) begin
                  state_q <= StIdle;
                  done_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   // Timestamp storage needs no reset: occupancy is tracked by the pointers/fill level.
   always_ff @(posedge lat_clk) begin
      for (int unsigned c = 0; c < NCH; c++) begin
         if (push[c]) fifo_mem_q[c][wr_idx_q[c]] <= timer_q;
      end
   end

   // FIFO bookkeeping, delta stage and statistics stage. A delta captured from an event
   // accepted in RUN always completes its update, even if the run ends meanwhile.
   always_ff @(posedge lat_clk or negedge lat_rstn) begin
      if (!lat_rstn) begin
         ovf_q     <= '0;
         unf_q     <= '0;
         dly_vld_q <= '0;
         for (int unsigned c = 0; c < NCH; c++) begin
            wr_idx_q[c] <= '0;
            rd_idx_q[c] <= '0;
            fill_q[c]   <= '0;
            dly_q[c]    <= '0;
            cnt_q[c]    <= '0;
            accu_q[c]   <= '0;
            min_q[c]    <= '1;
            max_q[c]    <= '0;
         end
      end else if (clr) begin
         ovf_q     <= '0;
         unf_q     <= '0;
         dly_vld_q <= '0;
         for (int unsigned c = 0; c < NCH; c++) begin
            wr_idx_q[c] <= '0;
            rd_idx_q[c] <= '0;
            fill_q[c]   <= '0;
            cnt_q[c]    <= '0;
            accu_q[c]   <= '0;
            min_q[c]    <= '1;
            max_q[c]    <= '0;
         end
      end else begin
         dly_vld_q <= pop;
         ovf_q     <= ovf_q | set_ovf;
         unf_q     <= unf_q | set_unf;
         for (int unsigned c = 0; c < NCH; c++) begin
            if (push[c]) begin
               wr_idx_q[c] <= (wr_idx_q[c] == IDX_W'(OUTST_DEPTH - 1)) ? '0
                                                                       : wr_idx_q[c] + IDX_W'(1);
            end
            if (pop[c]) begin
               rd_idx_q[c] <= (rd_idx_q[c] == IDX_W'(OUTST_DEPTH - 1)) ? '0
                                                                       : rd_idx_q[c] + IDX_W'(1);
               dly_q[c]    <= timer_q - fifo_mem_q[c][rd_idx_q[c]];
            end
            if (push[c] && !pop[c]) begin
               fill_q[c] <= fill_q[c] + FILL_W'(1);
            end else if (pop[c] && !push[c]) begin
               fill_q[c] <= fill_q[c] - FILL_W'(1);
            end
            if (take[c]) begin
               cnt_q[c]  <= cnt_q[c] + 32'd1;
               accu_q[c] <= accu_sum[c][ACCU_WIDTH] ? '1 : accu_sum[c][ACCU_WIDTH-1:0];
               if (dly_q[c] <= min_q[c]) min_q[c] <= dly_q[c];
               if (dly_q[c] >= max_q[c]) max_q[c] <= dly_q[c];
            end
         end
      end
   end

   // Registered readout mux; an unmatched rd_ch leaves the reset values in place.
   always_ff @(posedge lat_clk or negedge lat_rstn) begin
      if (!lat_rstn) begin
         rd_cnt_q  <= '0;
         rd_accu_q <= '0;
         rd_min_q  <= '1;
         rd_max_q  <= '0;
         rd_ovf_q  <= 1'b0;
         rd_unf_q  <= 1'b0;
      end else begin
         rd_cnt_q  <= '0;
         rd_accu_q <= '0;
         rd_min_q  <= '1;
         rd_max_q  <= '0;
         rd_ovf_q  <= 1'b0;
         rd_unf_q  <= 1'b0;
         for (int unsigned c = 0; c < NCH; c++) begin
            if (bus.rd_ch == CH_W'(c)) begin
               rd_cnt_q  <= cnt_q[c];
               rd_accu_q <= accu_q[c];
               rd_min_q  <= min_q[c];
               rd_max_q  <= max_q[c];
               rd_ovf_q  <= ovf_q[c];
               rd_unf_q  <= unf_q[c];
            end
         end
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.rd_cnt  = rd_cnt_q;
   assign bus.rd_accu = rd_accu_q;
   assign bus.rd_min  = rd_min_q;
   assign bus.rd_max  = rd_max_q;
   assign bus.rd_ovf  = rd_ovf_q;
   assign bus.rd_unf  = rd_unf_q;

`ifdef GTFMAC_VNC_LAT_HIST_EN
   localparam int unsigned BIN_W = (HIST_BINS > 1) ? $clog2(HIST_BINS) : 1;

   logic [31:0]      hist_q  [NCH][HIST_BINS];
   logic [BIN_W-1:0] bin_idx [NCH];
   logic [31:0]      rd_hist_q;

   always_comb begin
      for (int unsigned c = 0; c < NCH; c++) begin
         if ((dly_q[c] >> HIST_SHIFT) >= TIMER_WIDTH'(HIST_BINS - 1)) begin
            bin_idx[c] = BIN_W'(HIST_BINS - 1);
         end else begin
            bin_idx[c] = BIN_W'(dly_q[c] >> HIST_SHIFT);
         end
      end
   end

   always_ff @(posedge lat_clk or negedge lat_rstn) begin
      if (!lat_rstn) begin
         for (int unsigned c = 0; c < NCH; c++) begin
            for (int unsigned b = 0; b < HIST_BINS; b++) hist_q[c][b] <= '0;
         end
      end else begin
         for (int unsigned c = 0; c < NCH; c++) begin
            for (int unsigned b = 0; b < HIST_BINS; b++) begin
               if (clr) begin
                  hist_q[c][b] <= '0;
               end else if (take[c] && (bin_idx[c] == BIN_W'(b)) && (hist_q[c][b] != '1)) begin
                  hist_q[c][b] <= hist_q[c][b] + 32'd1;
               end
            end
         end
      end
   end

   always_ff @(posedge lat_clk or negedge lat_rstn) begin
      if (!lat_rstn) begin
         rd_hist_q <= '0;
      end else begin
         rd_hist_q <= '0;
         for (int unsigned c = 0; c < NCH; c++) begin
            for (int unsigned b = 0; b < HIST_BINS; b++) begin
               if ((bus.rd_ch == CH_W'(c)) && (bus.rd_bin == BIN_W'(b))) rd_hist_q <= hist_q[c][b];
            end
         end
      end
   end

   assign bus.rd_hist = rd_hist_q;
`else
   localparam int unsigned unused_hist_cfg = HIST_BINS + HIST_SHIFT;
   logic unused_rd_bin;
   assign unused_rd_bin = ^bus.rd_bin;
   assign bus.rd_hist   = '0;
`endif
endmodule

// File: tb/tb_gtfmac_vnc_lat_stats_mc.sv
module tb_gtfmac_vnc_lat_stats_mc;
   localparam int unsigned NCH   = 4;
   localparam int unsigned TW    = 16;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned AW    = 32;
   localparam int unsigned HB    = 16;
   localparam int unsigned HS    = 2;
   localparam int unsigned CH_W  = 2;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   gtfmac_vnc_lat_stats_mc_if #(.NCH(NCH), .TIMER_WIDTH(TW), .ACCU_WIDTH(AW), .HIST_BINS(HB)) bus ();

   gtfmac_vnc_lat_stats_mc #(
      .NCH(NCH), .TIMER_WIDTH(TW), .OUTST_DEPTH(DEPTH), .ACCU_WIDTH(AW),
      .HIST_BINS(HB), .HIST_SHIFT(HS)
   ) dut (
      .lat_clk(clk),
      .lat_rstn(rstn),
      .bus(bus)
   );

   // Bench copy of the free-running timer: after each active edge it equals the DUT timer,
   // which is the stamp an event driven now will receive at the next edge.
   logic [15:0] now_q;
   always @(posedge clk or negedge rstn) begin
      if (!rstn) now_q <= 16'd0;
      else       now_q <= now_q + 16'd1;
   end

   int n_chk = 0;
   int n_bad = 0;

   // Reference model state
   int unsigned    m_q    [NCH][$];
   longint unsigned m_cnt [NCH];
   longint unsigned m_accu[NCH];
   int unsigned    m_min  [NCH];
   int unsigned    m_max  [NCH];
   bit             m_ovf  [NCH];
   bit             m_unf  [NCH];
   int unsigned    m_hist [NCH][HB];

   typedef struct {
      int ch;
      int gap_a;
      int gap_b;
      int reps;
      longint cnt;
      longint accu;
      longint mn;
      longint mx;
   } vec_t;
   vec_t tbl[4];

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic pulse(logic [NCH-1:0] s, logic [NCH-1:0] r);
      bus.send_event = s;
      bus.rcv_event  = r;
      tick();
      bus.send_event = '0;
      bus.rcv_event  = '0;
   endtask

   // send on ch, receive gap cycles later (gap >= 1)
   task automatic pair(int ch, int gap);
      logic [NCH-1:0] m;
      m = '0;
      m[ch] = 1'b1;
      pulse(m, '0);
      idle(gap - 1);
      pulse('0, m);
   endtask

   task automatic chk_ch(string nm, int ch, logic [31:0] cnt, logic [31:0] accu,
                         logic [15:0] mn, logic [15:0] mx, logic ovf, logic unf);
      bus.rd_ch = CH_W'(ch);
      tick();
      chk($sformatf("%s ch%0d cnt", nm, ch), bus.rd_cnt, cnt);
      chk($sformatf("%s ch%0d accu", nm, ch), bus.rd_accu, accu);
      chk($sformatf("%s ch%0d min", nm, ch), bus.rd_min, mn);
      chk($sformatf("%s ch%0d max", nm, ch), bus.rd_max, mx);
      chk($sformatf("%s ch%0d ovf", nm, ch), bus.rd_ovf, ovf);
      chk($sformatf("%s ch%0d unf", nm, ch), bus.rd_unf, unf);
`ifndef GTFMAC_VNC_LAT_HIST_EN
      chk($sformatf("%s ch%0d hist", nm, ch), bus.rd_hist, 0);
`endif
   endtask

   task automatic start_run(int target);
      bus.lat_pkt_cnt = target;
      bus.go = 1'b1;
      tick();
   endtask

   task automatic stop_clear();
      bus.go = 1'b0;
      tick();
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      tick();
   endtask

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_q[c].delete();
         m_cnt[c]  = 0;
         m_accu[c] = 0;
         m_min[c]  = 32'hFFFF;
         m_max[c]  = 0;
         m_ovf[c]  = 0;
         m_unf[c]  = 0;
         for (int b = 0; b < HB; b++) m_hist[c][b] = 0;
      end
   endtask

   // Receive is handled before send: a same-cycle pair pops the old head, then pushes.
   task automatic model_step(logic [NCH-1:0] s, logic [NCH-1:0] r, logic [15:0] t);
      int unsigned d, b;
      for (int c = 0; c < NCH; c++) begin
         if (r[c]) begin
            if (m_q[c].size() == 0) begin
               m_unf[c] = 1;
            end else begin
               d = (32'(t) - m_q[c].pop_front()) & 32'hFFFF;
               m_cnt[c]++;
               m_accu[c] = m_accu[c] + d;
               if (m_accu[c] > 64'hFFFF_FFFF) m_accu[c] = 64'hFFFF_FFFF;
               if (d < m_min[c]) m_min[c] = d;
               if (d > m_max[c]) m_max[c] = d;
               b = d >> HS;
               if (b > HB - 1) b = HB - 1;
               m_hist[c][b]++;
            end
         end
         if (s[c]) begin
            if (m_q[c].size() < DEPTH) m_q[c].push_back(32'(t));
            else m_ovf[c] = 1;
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int guard;
      tbl[0] = '{0, 10, 10, 1, 1, 10, 10, 10};
      tbl[1] = '{1, 4, 9, 3, 3, 17, 4, 9};
      tbl[2] = '{2, 1, 2, 4, 4, 6, 1, 2};
      tbl[3] = '{3, 20, 3, 2, 2, 23, 3, 20};

      bus.go = 1'b0;
      bus.clear = 1'b0;
      bus.lat_pkt_cnt = 32'd0;
      bus.send_event = '0;
      bus.rcv_event = '0;
      bus.rd_ch = '0;
      bus.rd_bin = '0;

      // Reset values
      idle(2);
      chk_ch("reset", 0, 0, 0, 16'hFFFF, 0, 0, 0);
      chk("reset busy", bus.busy, 0);
      chk("reset done", bus.done, 0);
      rstn = 1'b1;
      idle(2);

      // Basic run: target 3, all channels, delta 10 three times
      start_run(3);
      chk("run busy", bus.busy, 1);
      for (int i = 0; i < 3; i++) begin
         pulse(4'hF, '0);
         idle(9);
         pulse('0, 4'hF);
      end
      idle(4);
      chk("target done", bus.done, 1);
      chk("target busy", bus.busy, 0);
      chk_ch("target", 0, 3, 30, 10, 10, 0, 0);
      chk_ch("target", 3, 3, 30, 10, 10, 0, 0);
      stop_clear();
      chk("clear done", bus.done, 0);
      chk_ch("cleared", 0, 0, 0, 16'hFFFF, 0, 0, 0);

      // Table-driven pairs, unlimited target
      start_run(0);
      foreach (tbl[i]) begin
         for (int r = 0; r < tbl[i].reps; r++) pair(tbl[i].ch, (r % 2) ? tbl[i].gap_b : tbl[i].gap_a);
      end
      idle(3);
      foreach (tbl[i]) begin
         chk_ch("table", tbl[i].ch, 32'(tbl[i].cnt), 32'(tbl[i].accu), 16'(tbl[i].mn),
                16'(tbl[i].mx), 0, 0);
      end
      chk("table busy", bus.busy, 1);
      stop_clear();

      // Sample limit: third sample on ch0 is dropped but still pops its FIFO
      start_run(2);
      pair(0, 3);
      pair(0, 4);
      pair(0, 5);
      idle(3);
      chk_ch("limit", 0, 2, 7, 3, 4, 0, 0);
      chk("limit busy", bus.busy, 1);
      pulse('0, 4'b0001);
      idle(3);
      chk_ch("limit pop", 0, 2, 7, 3, 4, 0, 1);
      stop_clear();

      // Timer wrap, overflow/underflow, same-cycle corner cases
      start_run(0);
      guard = 0;
      while (now_q != 16'hFFFA && guard < 70000) begin
         tick();
         guard++;
      end
      chk("wrap reach", now_q, 16'hFFFA);
      pair(0, 10);
      bus.rd_ch = CH_W'(1);
      for (int i = 0; i < 9; i++) pulse(4'b0010, '0);
      pulse('0, 4'b0010);
      chk("ovf after 9 sends", bus.rd_ovf, 1);
      chk("no unf yet", bus.rd_unf, 0);
      for (int i = 0; i < 8; i++) pulse('0, 4'b0010);
      pulse(4'b0100, 4'b0100);
      idle(4);
      pulse('0, 4'b0100);
      for (int i = 0; i < 8; i++) pulse(4'b1000, '0);
      pulse(4'b1000, 4'b1000);
      idle(3);
      chk_ch("wrap", 0, 1, 10, 10, 10, 0, 0);
      chk_ch("ovfunf", 1, 8, 72, 9, 9, 1, 1);
      chk_ch("same empty", 2, 1, 5, 5, 5, 0, 1);
      chk_ch("same full", 3, 1, 8, 8, 8, 0, 0);
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      chk("clear in run busy", bus.busy, 1);
      bus.go = 1'b0;
      tick();
      chk("go fall done", bus.done, 1);
      chk("go fall busy", bus.busy, 0);
      pulse(4'hF, 4'hF);
      idle(3);
      chk_ch("frozen", 0, 1, 10, 10, 10, 0, 0);
      chk_ch("frozen", 2, 1, 5, 5, 5, 0, 1);
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      tick();
      chk("after clear done", bus.done, 0);
      chk("after clear busy", bus.busy, 0);
      for (int c = 0; c < NCH; c++) chk_ch("after clear", c, 0, 0, 16'hFFFF, 0, 0, 0);

`ifdef GTFMAC_VNC_LAT_HIST_EN
      start_run(0);
      pair(0, 3);
      pair(0, 7);
      pair(0, 200);
      idle(3);
      bus.rd_ch = '0;
      for (int b = 0; b < HB; b++) begin
         bus.rd_bin = 4'(b);
         tick();
         chk($sformatf("hist bin%0d", b), bus.rd_hist, (b == 0 || b == 1 || b == 15) ? 1 : 0);
      end
      stop_clear();
`endif

      // Randomized traffic against the reference model
      model_reset();
      start_run(0);
      for (int n = 0; n < 600; n++) begin
         logic [NCH-1:0] s, r;
         for (int c = 0; c < NCH; c++) begin
            s[c] = ($urandom_range(0, 99) < 55);
            r[c] = ($urandom_range(0, 99) < 45);
         end
         model_step(s, r, now_q);
         pulse(s, r);
      end
      idle(4);
      bus.go = 1'b0;
      tick();
      for (int c = 0; c < NCH; c++) begin
         chk_ch("random", c, 32'(m_cnt[c]), 32'(m_accu[c]), 16'(m_min[c]), 16'(m_max[c]),
                m_ovf[c], m_unf[c]);
`ifdef GTFMAC_VNC_LAT_HIST_EN
         for (int b = 0; b < HB; b++) begin
            bus.rd_bin = 4'(b);
            tick();
            chk($sformatf("random ch%0d bin%0d", c, b), bus.rd_hist, m_hist[c][b]);
         end
`endif
      end
      stop_clear();

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
